// File: rtl/i2s_feat_pkg.sv
`default_nettype none
// ============================================================================
// i2s_feat_pkg: shared constants, FSM state type and centring clamp.
// Rev 1.0
// ============================================================================
package i2s_feat_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int FL_DEFAULT = 8;
  localparam int FRAME_LEN  = 2 ** FL_DEFAULT;
  localparam int ZCR_W      = FL_DEFAULT + 1;
  localparam int STE_W      = 2 * DW_DEFAULT + FL_DEFAULT;

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  // a - b at one extra bit; overflow shows up as the top two bits disagreeing.
  function automatic logic [DW_DEFAULT-1:0] sat_sub(input logic [DW_DEFAULT-1:0] a,
                                                    input logic [DW_DEFAULT-1:0] b);
    logic [DW_DEFAULT:0] diff;
    diff = {a[DW_DEFAULT-1], a} - {b[DW_DEFAULT-1], b};
    if (diff[DW_DEFAULT] != diff[DW_DEFAULT-1])
      return {diff[DW_DEFAULT], {(DW_DEFAULT-1){~diff[DW_DEFAULT]}}};
    return diff[DW_DEFAULT-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_feature_extractor_mean.sv
`default_nettype none
// ============================================================================
// frame_mean_tracker: raw-sample sum, frame counter and per-frame mean register.
// Rev 1.0
// ============================================================================
module frame_mean_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LOG2 = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  restart_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] mean_o
);

  localparam int SUM_W = DATA_WIDTH + FRAME_LOG2;

  logic [FRAME_LOG2-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]      sum_q, sum_d, w_sum_nxt;
  logic [DATA_WIDTH-1:0] mean_q, mean_d;

  assign w_sum_nxt = sum_q + {{FRAME_LOG2{data_i[DATA_WIDTH-1]}}, data_i};
  assign last_o    = vld_i && (cnt_q == '1);
  assign mean_o    = mean_q;

  always_comb begin
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    mean_d = mean_q;
    if (restart_i) begin
      cnt_d  = '0;
      sum_d  = '0;
      mean_d = '0;
    end else if (vld_i) begin
      cnt_d = cnt_q + FRAME_LOG2'(1);
      if (last_o) begin
        // Taking the top bits is the floor-division arithmetic shift.
        mean_d = w_sum_nxt[SUM_W-1:FRAME_LOG2];
        sum_d  = '0;
      end else begin
        sum_d = w_sum_nxt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sum_q  <= '0;
      mean_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      mean_q <= mean_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_feature_extractor.sv
`default_nettype none
// ============================================================================
// frame_feature_extractor: DC removal plus per-frame ZCR, energy and mean.
// Rev 1.0
// ============================================================================
module frame_feature_extractor
  import i2s_feat_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEFAULT,
  parameter int FRAME_LOG2 = FL_DEFAULT
) (
  input  logic                               i_sys_clk,
  input  logic                               i_sys_rst_n,
  input  logic                               i_restart,
  input  logic [DATA_WIDTH-1:0]              i_data,
  input  logic                               i_vld,
  output logic [DATA_WIDTH-1:0]              o_cent,
  output logic                               o_cent_vld,
  output logic [FRAME_LOG2:0]                o_zcr,
  output logic [2*DATA_WIDTH+FRAME_LOG2-1:0] o_ste,
  output logic [DATA_WIDTH-1:0]              o_mean,
  output logic                               o_frame_vld,
  output logic                               o_warm
);

  localparam int ZW = FRAME_LOG2 + 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW + FRAME_LOG2;

  state_e                 state_q, state_d;
  logic                   w_acc, w_last;
  logic [DATA_WIDTH-1:0]  w_mean, w_mean_eff, w_cent;
  logic signed [PW-1:0]   w_sq;
  logic [ZW-1:0]          w_zcr_sum;
  logic [SW-1:0]          w_ste_sum;

  logic [DATA_WIDTH-1:0]  cent_q;
  logic                   cent_vld_q, last1_q;
  logic [PW-1:0]          sq_q;
  logic                   zc_q, vld2_q, last2_q, prev_neg_q, have_prev_q;
  logic [ZW-1:0]          zcr_acc_q, zcr_q;
  logic [SW-1:0]          ste_acc_q, ste_q;
  logic [DATA_WIDTH-1:0]  mean_pub_q;
  logic                   frame_vld_q;

  // A sample coinciding with restart is dropped.
  assign w_acc = i_vld && !i_restart;

  frame_mean_tracker #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAME_LOG2(FRAME_LOG2)
  ) u_mean (
    .clk_i    (i_sys_clk),
    .rst_ni   (i_sys_rst_n),
    .restart_i(i_restart),
    .vld_i    (w_acc),
    .data_i   (i_data),
    .last_o   (w_last),
    .mean_o   (w_mean)
  );

  assign w_mean_eff = (state_q == RUN) ? w_mean : '0;

  generate
    if (DATA_WIDTH == DW_DEFAULT) begin : g_sat_pkg
      assign w_cent = sat_sub(i_data, w_mean_eff);
    end else begin : g_sat_generic
      logic [DATA_WIDTH:0] w_diff;
      assign w_diff = {i_data[DATA_WIDTH-1], i_data} - {w_mean_eff[DATA_WIDTH-1], w_mean_eff};
      assign w_cent = (w_diff[DATA_WIDTH] != w_diff[DATA_WIDTH-1])
                    ? {w_diff[DATA_WIDTH], {(DATA_WIDTH-1){~w_diff[DATA_WIDTH]}}}
                    : w_diff[DATA_WIDTH-1:0];
    end
  endgenerate

  assign w_sq      = $signed(cent_q) * $signed(cent_q);
  assign w_zcr_sum = zcr_acc_q + ZW'(zc_q);
  assign w_ste_sum = ste_acc_q + SW'(sq_q);

  always_comb begin
    state_d = state_q;
    if (i_restart)
      state_d = WARMUP;
    else if (state_q == WARMUP && w_last)
      state_d = RUN;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n)
      state_q <= WARMUP;
    else
      state_q <= state_d;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      cent_q      <= '0;
      cent_vld_q  <= 1'b0;
      last1_q     <= 1'b0;
      sq_q        <= '0;
      zc_q        <= 1'b0;
      vld2_q      <= 1'b0;
      last2_q     <= 1'b0;
      prev_neg_q  <= 1'b0;
      have_prev_q <= 1'b0;
      zcr_acc_q   <= '0;
      ste_acc_q   <= '0;
      zcr_q       <= '0;
      ste_q       <= '0;
      mean_pub_q  <= '0;
      frame_vld_q <= 1'b0;
    end else begin
      cent_vld_q  <= w_acc;
      last1_q     <= w_last;
      if (w_acc)
        cent_q <= w_cent;

      vld2_q      <= cent_vld_q && !i_restart;
      last2_q     <= last1_q;
      if (i_restart) begin
        prev_neg_q  <= 1'b0;
        have_prev_q <= 1'b0;
      end else if (cent_vld_q) begin
        sq_q        <= $unsigned(w_sq);
        zc_q        <= have_prev_q && (cent_q[DATA_WIDTH-1] != prev_neg_q);
        prev_neg_q  <= cent_q[DATA_WIDTH-1];
        have_prev_q <= 1'b1;
      end

      // Publishing reseeds the accumulators so the next frame starts bubble-free.
      frame_vld_q <= 1'b0;
      if (i_restart) begin
        zcr_acc_q <= '0;
        ste_acc_q <= '0;
      end else if (vld2_q) begin
        if (last2_q) begin
          zcr_acc_q   <= '0;
          ste_acc_q   <= '0;
          zcr_q       <= w_zcr_sum;
          ste_q       <= w_ste_sum;
          mean_pub_q  <= w_mean;
          frame_vld_q <= 1'b1;
        end else begin
          zcr_acc_q <= w_zcr_sum;
          ste_acc_q <= w_ste_sum;
        end
      end
    end
  end

  assign o_cent      = cent_q;
  assign o_cent_vld  = cent_vld_q;
  assign o_zcr       = zcr_q;
  assign o_ste       = ste_q;
  assign o_mean      = mean_pub_q;
  assign o_frame_vld = frame_vld_q;
  assign o_warm      = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_frame_feature_extractor.sv
`default_nettype none
// ============================================================================
// tb_frame_feature_extractor: randomized bench against a frame-level model.
// Rev 1.0
// ============================================================================
module tb_frame_feature_extractor;

  localparam int DW = 16;
  localparam int N0 = 256;
  localparam int N1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n;
  logic          rs0, v0, rs1, v1;
  logic [DW-1:0] d0, d1;

  logic [DW-1:0] cent0, mean0, cent1, mean1;
  logic          cvld0, fvld0, warm0, cvld1, fvld1, warm1;
  logic [8:0]    zcr0;
  logic [39:0]   ste0;
  logic [2:0]    zcr1;
  logic [33:0]   ste1;

  frame_feature_extractor #(.DATA_WIDTH(DW), .FRAME_LOG2(8)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_restart(rs0), .i_data(d0), .i_vld(v0),
    .o_cent(cent0), .o_cent_vld(cvld0), .o_zcr(zcr0), .o_ste(ste0), .o_mean(mean0),
    .o_frame_vld(fvld0), .o_warm(warm0)
  );

  frame_feature_extractor #(.DATA_WIDTH(DW), .FRAME_LOG2(2)) dut4 (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_restart(rs1), .i_data(d1), .i_vld(v1),
    .o_cent(cent1), .o_cent_vld(cvld1), .o_zcr(zcr1), .o_ste(ste1), .o_mean(mean1),
    .o_frame_vld(fvld1), .o_warm(warm1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int     zcr;
    longint ste;
    int     mean;
    int     cyc;
  } frame_t;

  int     exp_cent[$];
  frame_t exp_fr[$];
  int     raw0[$];
  int     cf0[$];
  int     m_mean;
  bit     have_last;
  int     last_cent;
  int     raw1[$];
  int     exp_cyc1[$];
  int     exp_mean1[$];

  function automatic int clamp(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor_div(input longint s, input int n);
    if (s >= 0) return int'(s / n);
    return -int'((-s + n - 1) / n);
  endfunction

  task automatic model_reset();
    exp_cent.delete(); exp_fr.delete(); raw0.delete(); cf0.delete();
    raw1.delete(); exp_cyc1.delete(); exp_mean1.delete();
    m_mean = 0; have_last = 0; last_cent = 0;
  endtask

  task automatic model0_restart();
    raw0.delete(); cf0.delete();
    m_mean = 0; have_last = 0;
  endtask

  task automatic model0(input int x);
    int     c, z, pv;
    bit     hp;
    longint s, e;
    frame_t f;
    c = clamp(x - m_mean);
    exp_cent.push_back(c);
    raw0.push_back(x);
    cf0.push_back(c);
    if (raw0.size() == N0) begin
      s = 0; e = 0; z = 0;
      hp = have_last; pv = last_cent;
      for (int i = 0; i < N0; i++) begin
        s += raw0[i];
        e += longint'(cf0[i]) * longint'(cf0[i]);
        if (hp && ((cf0[i] < 0) != (pv < 0))) z++;
        pv = cf0[i];
        hp = 1'b1;
      end
      f.zcr = z; f.ste = e; f.mean = floor_div(s, N0); f.cyc = cyc + 2;
      exp_fr.push_back(f);
      m_mean    = f.mean;
      last_cent = cf0[N0-1];
      have_last = 1'b1;
      raw0.delete(); cf0.delete();
    end
  endtask

  task automatic drive0(input bit v, input int x, input bit rs);
    v0 = v; d0 = x[DW-1:0]; rs0 = rs;
    @(posedge clk); #1;
    if (rs) model0_restart();
    else if (v) model0(x);
    v0 = 1'b0; rs0 = 1'b0;
  endtask

  task automatic drive1(input bit v, input int x);
    longint s;
    v1 = v; d1 = x[DW-1:0];
    @(posedge clk); #1;
    if (v) begin
      raw1.push_back(x);
      if (raw1.size() == N1) begin
        s = 0;
        foreach (raw1[i]) s += raw1[i];
        exp_mean1.push_back(floor_div(s, N1));
        exp_cyc1.push_back(cyc + 2);
        raw1.delete();
      end
    end
    v1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive0(1'b0, 0, 1'b0);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  always @(negedge clk) begin : mon
    frame_t f;
    if (rst_n) begin
      if (cvld0) begin
        if (exp_cent.size() == 0) check_eq("cent_extra", 1, 0);
        else check_eq("cent", $signed(cent0), exp_cent.pop_front());
      end
      if (fvld0) begin
        if (exp_fr.size() == 0) check_eq("frame_extra", 1, 0);
        else begin
          f = exp_fr.pop_front();
          check_eq("zcr", zcr0, f.zcr);
          check_eq("ste", ste0, f.ste);
          check_eq("mean", $signed(mean0), f.mean);
          check_eq("frame_lat", cyc, f.cyc);
          check_eq("warm_at_frame", warm0, 1);
        end
      end
      if (fvld1) begin
        if (exp_cyc1.size() == 0) check_eq("frame4_extra", 1, 0);
        else begin
          check_eq("frame4_lat", cyc, exp_cyc1.pop_front());
          check_eq("mean4", $signed(mean1), exp_mean1.pop_front());
          check_eq("warm4", warm1, 1);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_cent"}, cent0, 0);
    check_eq({tag, "_cent_vld"}, cvld0, 0);
    check_eq({tag, "_zcr"}, zcr0, 0);
    check_eq({tag, "_ste"}, ste0, 0);
    check_eq({tag, "_mean"}, mean0, 0);
    check_eq({tag, "_frame_vld"}, fvld0, 0);
    check_eq({tag, "_warm"}, warm0, 0);
  endtask

  task automatic check_drained(input string tag);
    check_eq({tag, "_pend_cent"}, exp_cent.size(), 0);
    check_eq({tag, "_pend_frame"}, exp_fr.size(), 0);
    check_eq({tag, "_pend_frame4"}, exp_cyc1.size(), 0);
  endtask

  initial begin
    int got;
    rst_n = 1'b0; v0 = 1'b0; d0 = '0; rs0 = 1'b0; v1 = 1'b0; d1 = '0; rs1 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Constant input
    for (int i = 0; i < 512; i++) drive0(1'b1, 1000, 1'b0);
    idle(4);
    check_eq("warm_after_const", warm0, 1);
    drive0(1'b0, 0, 1'b1);
    check_eq("warm_after_restart", warm0, 0);

    // Alternating +/-100
    for (int i = 0; i < 512; i++) drive0(1'b1, (i % 2 == 0) ? 100 : -100, 1'b0);
    idle(4);
    drive0(1'b0, 0, 1'b1);

    // Saturation
    for (int i = 0; i < 256; i++) drive0(1'b1, -32768, 1'b0);
    for (int i = 0; i < 256; i++) drive0(1'b1, 32767, 1'b0);
    idle(4);
    drive0(1'b0, 0, 1'b1);

    // Random data with random gaps
    got = 0;
    while (got < 3 * N0 + 37) begin
      if ($urandom_range(0, 3) == 0) drive0(1'b0, 0, 1'b0);
      else begin
        drive0(1'b1, ($urandom_range(0, 1) == 1) ? rnd16() : int'($urandom_range(0, 400)) - 200, 1'b0);
        got++;
      end
    end
    idle(4);

    // Restart mid-frame, then a fresh frame centred on mean 0
    drive0(1'b0, 0, 1'b1);
    for (int i = 0; i < 100; i++) drive0(1'b1, rnd16(), 1'b0);
    idle(4);
    drive0(1'b0, 0, 1'b1);
    check_eq("warm_mid_restart", warm0, 0);
    for (int i = 0; i < 256; i++) drive0(1'b1, int'($urandom_range(0, 2000)) + 500, 1'b0);
    idle(4);

    // Restart coincident with a valid sample drops that sample
    drive0(1'b1, 12345, 1'b1);
    for (int i = 0; i < 256; i++) drive0(1'b1, rnd16(), 1'b0);
    idle(4);
    check_drained("mid");

    // Short-frame instance: 50 frames full rate, 50 frames with gaps
    for (int i = 0; i < 200; i++) drive1(1'b1, rnd16());
    got = 0;
    while (got < 200) begin
      if ($urandom_range(0, 2) == 0) drive1(1'b0, 0);
      else begin
        drive1(1'b1, rnd16());
        got++;
      end
    end
    repeat (4) drive1(1'b0, 0);
    check_drained("short");

    // Async reset between edges, with samples still in flight
    drive0(1'b0, 0, 1'b1);
    for (int i = 0; i < 50; i++) drive0(1'b1, rnd16(), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async");
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) drive0(1'b1, (i % 2 == 0) ? 500 : -500, 1'b0);
    for (int i = 0; i < 256; i++) drive0(1'b1, rnd16(), 1'b0);
    idle(5);
    check_drained("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
